// File: rtl/mem_readout_pkg.sv
// readout_pkg: shared FSM state type and word geometry for the memory readout engine.
package readout_pkg;

    localparam int WORD_W = 32;
    localparam int BYTES_PER_WORD = WORD_W / 8;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} readout_state_t;

    function automatic int idx_width(input int nb);
        return nb > 1 ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/mem_readout_word_serializer.sv
// word_serializer: holds one memory word and shifts it out LSB byte first on each handshake.
module word_serializer
    import readout_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    output logic [7:0]        tx_data,
    output logic              last
);

    localparam int NB = DATA_W / 8;
    localparam int IW = idx_width(NB);

    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;

    always_comb begin
        shreg_d = load ? load_data : shift ? shreg_q >> 8 : shreg_q;
        idx_d   = load ? '0 : shift ? idx_q + IW'(1) : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_data = shreg_q[7:0];
    assign last    = idx_q == IW'(NB - 1);

endmodule

// File: rtl/mem_readout.sv
// mem_readout: fetches a range of memory words and streams them out as little-endian bytes.
module mem_readout
    import readout_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = WORD_W,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    readout_state_t    state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, done_q, rd_en_q, valid_q;
    logic              last, fire;

    assign fire = valid_q && tx_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = word_count != '0 ? REQ : DONE;
                if (word_count != '0) begin
                    addr_d = base_addr;
                    cnt_d  = word_count;
                end
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                state_d = SEND;
                addr_d  = addr_q + ADDR_W'(1);
                cnt_d   = cnt_q - CNT_W'(1);
            end
            SEND: if (fire && last) state_d = cnt_q != '0 ? REQ : DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            busy_q  <= state_d == REQ || state_d == WAIT || state_d == SEND;
            done_q  <= state_d == DONE;
            rd_en_q <= state_d == REQ;
            valid_q <= state_d == SEND;
        end
    end

    word_serializer #(.DATA_W(DATA_W)) u_ser (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == WAIT),
        .load_data(mem_rdata),
        .shift    (fire),
        .tx_data  (tx_data),
        .last     (last)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign tx_valid  = valid_q;

endmodule
